// File: rtl/canvas_writer.sv
// rtl/canvas_writer.sv - command-driven pixel writer owning the canvas RAM write port
module canvas_writer #(
  parameter int COLS   = 320,
  parameter int ROWS   = 240,
  parameter int COL_W  = 9,
  parameter int ROW_W  = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  input  logic [31:0]       cmd_data_i,
  output logic              cmd_ready_o,
  output logic              busy_o,
  output logic              we_o,
  output logic [COL_W-1:0]  col_o,
  output logic [ROW_W-1:0]  row_o,
  output logic [DATA_W-1:0] data_o
);

  typedef enum logic {S_IDLE, S_FILL} state_t;

  localparam logic [COL_W:0] C_COLS = (COL_W+1)'(COLS);
  localparam logic [ROW_W:0] C_ROWS = (ROW_W+1)'(ROWS);

  localparam logic [3:0] OP_SET_COLOR = 4'h1;
  localparam logic [3:0] OP_SET_POS   = 4'h2;
  localparam logic [3:0] OP_PLOT      = 4'h3;
  localparam logic [3:0] OP_FILL_RECT = 4'h4;
  localparam logic [3:0] OP_CLEAR     = 4'h5;

  state_t              r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_colour, w_colour_nxt;
  logic [COL_W-1:0]    r_pos_col, w_pos_col_nxt;
  logic [ROW_W-1:0]    r_pos_row, w_pos_row_nxt;
  // Active fill: size, origin and the (x,y) of the pixel emitted on the next edge
  logic [COL_W-1:0]    r_fw, w_fw_nxt, r_fx, w_fx_nxt, r_fbc, w_fbc_nxt;
  logic [ROW_W-1:0]    r_fh, w_fh_nxt, r_fy, w_fy_nxt, r_fbr, w_fbr_nxt;
  logic                w_ready_nxt, w_busy_nxt, w_we_nxt;
  logic [COL_W-1:0]    w_col_nxt;
  logic [ROW_W-1:0]    w_row_nxt;
  logic [DATA_W-1:0]   w_data_nxt;

  logic [3:0]          w_op;
  logic                w_acc;
  logic [COL_W-1:0]    w_new_w, w_new_bc, w_src_w, w_src_x, w_src_bc, w_adv_x;
  logic [ROW_W-1:0]    w_new_h, w_new_br, w_src_h, w_src_y, w_src_br, w_adv_y;
  logic [COL_W:0]      w_px_col;
  logic [ROW_W:0]      w_px_row;
  logic                w_px_in, w_last, w_plot_in, w_plot_col_wrap;

  assign w_op  = cmd_data_i[31:28];
  assign w_acc = cmd_valid_i && cmd_ready_o && (r_state == S_IDLE);

  // CLEAR is a fill of the whole canvas from the origin, leaving pos untouched
  assign w_new_w  = (w_op == OP_CLEAR) ? C_COLS[COL_W-1:0] : cmd_data_i[COL_W-1:0];
  assign w_new_h  = (w_op == OP_CLEAR) ? C_ROWS[ROW_W-1:0] : cmd_data_i[COL_W+ROW_W-1:COL_W];
  assign w_new_bc = (w_op == OP_CLEAR) ? '0 : r_pos_col;
  assign w_new_br = (w_op == OP_CLEAR) ? '0 : r_pos_row;

  // The accept edge emits pixel (0,0) of the new fill; later edges use the stored state
  assign w_src_w  = (r_state == S_FILL) ? r_fw  : w_new_w;
  assign w_src_h  = (r_state == S_FILL) ? r_fh  : w_new_h;
  assign w_src_x  = (r_state == S_FILL) ? r_fx  : '0;
  assign w_src_y  = (r_state == S_FILL) ? r_fy  : '0;
  assign w_src_bc = (r_state == S_FILL) ? r_fbc : w_new_bc;
  assign w_src_br = (r_state == S_FILL) ? r_fbr : w_new_br;

  // One extra bit so pixels past the right/bottom edge clip instead of wrapping
  assign w_px_col = {1'b0, w_src_bc} + {1'b0, w_src_x};
  assign w_px_row = {1'b0, w_src_br} + {1'b0, w_src_y};
  assign w_px_in  = (w_px_col < C_COLS) && (w_px_row < C_ROWS);

  assign w_last  = (w_src_x == w_src_w - 1'b1) && (w_src_y == w_src_h - 1'b1);
  assign w_adv_x = (w_src_x == w_src_w - 1'b1) ? '0 : w_src_x + 1'b1;
  assign w_adv_y = (w_src_x == w_src_w - 1'b1) ? w_src_y + 1'b1 : w_src_y;

  assign w_plot_in       = ({1'b0, r_pos_col} < C_COLS) && ({1'b0, r_pos_row} < C_ROWS);
  assign w_plot_col_wrap = ({1'b0, r_pos_col} >= C_COLS - 1'b1);

  // Next-state and next-output decode for command accept and fill stepping
  always_comb begin
    w_state_nxt   = r_state;
    w_ready_nxt   = cmd_ready_o;
    w_busy_nxt    = busy_o;
    w_we_nxt      = 1'b0;
    w_col_nxt     = col_o;
    w_row_nxt     = row_o;
    w_data_nxt    = data_o;
    w_colour_nxt  = r_colour;
    w_pos_col_nxt = r_pos_col;
    w_pos_row_nxt = r_pos_row;
    w_fw_nxt      = r_fw;
    w_fh_nxt      = r_fh;
    w_fx_nxt      = r_fx;
    w_fy_nxt      = r_fy;
    w_fbc_nxt     = r_fbc;
    w_fbr_nxt     = r_fbr;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          case (w_op)
            OP_SET_COLOR: w_colour_nxt = cmd_data_i[DATA_W-1:0];
            OP_SET_POS: begin
              w_pos_col_nxt = cmd_data_i[COL_W-1:0];
              w_pos_row_nxt = cmd_data_i[COL_W+ROW_W-1:COL_W];
            end
            OP_PLOT: begin
              if (w_plot_in) begin
                w_we_nxt   = 1'b1;
                w_col_nxt  = r_pos_col;
                w_row_nxt  = r_pos_row;
                w_data_nxt = r_colour;
              end
              if (w_plot_col_wrap) begin
                w_pos_col_nxt = '0;
                w_pos_row_nxt = ({1'b0, r_pos_row} == C_ROWS - 1'b1) ? '0 : r_pos_row + 1'b1;
              end else begin
                w_pos_col_nxt = r_pos_col + 1'b1;
              end
            end
            OP_FILL_RECT, OP_CLEAR: begin
              if ((w_new_w != '0) && (w_new_h != '0)) begin
                if (w_px_in) begin
                  w_we_nxt   = 1'b1;
                  w_col_nxt  = w_px_col[COL_W-1:0];
                  w_row_nxt  = w_px_row[ROW_W-1:0];
                  w_data_nxt = r_colour;
                end
                w_fw_nxt  = w_new_w;
                w_fh_nxt  = w_new_h;
                w_fbc_nxt = w_new_bc;
                w_fbr_nxt = w_new_br;
                if (!w_last) begin
                  w_state_nxt = S_FILL;
                  w_ready_nxt = 1'b0;
                  w_busy_nxt  = 1'b1;
                  w_fx_nxt    = w_adv_x;
                  w_fy_nxt    = w_adv_y;
                end
              end
            end
            default: ;
          endcase
        end
      end
      S_FILL: begin
        if (w_px_in) begin
          w_we_nxt   = 1'b1;
          w_col_nxt  = w_px_col[COL_W-1:0];
          w_row_nxt  = w_px_row[ROW_W-1:0];
          w_data_nxt = r_colour;
        end
        if (w_last) begin
          w_state_nxt = S_IDLE;
          w_ready_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
        end else begin
          w_fx_nxt = w_adv_x;
          w_fy_nxt = w_adv_y;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, working registers and registered RAM port outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      cmd_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      we_o        <= 1'b0;
      col_o       <= '0;
      row_o       <= '0;
      data_o      <= '0;
      r_colour    <= '0;
      r_pos_col   <= '0;
      r_pos_row   <= '0;
      r_fw        <= '0;
      r_fh        <= '0;
      r_fx        <= '0;
      r_fy        <= '0;
      r_fbc       <= '0;
      r_fbr       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      cmd_ready_o <= w_ready_nxt;
      busy_o      <= w_busy_nxt;
      we_o        <= w_we_nxt;
      col_o       <= w_col_nxt;
      row_o       <= w_row_nxt;
      data_o      <= w_data_nxt;
      r_colour    <= w_colour_nxt;
      r_pos_col   <= w_pos_col_nxt;
      r_pos_row   <= w_pos_row_nxt;
      r_fw        <= w_fw_nxt;
      r_fh        <= w_fh_nxt;
      r_fx        <= w_fx_nxt;
      r_fy        <= w_fy_nxt;
      r_fbc       <= w_fbc_nxt;
      r_fbr       <= w_fbr_nxt;
    end
  end

endmodule

// File: tb/tb_canvas_writer.sv
// tb/tb_canvas_writer.sv - directed self-checking bench for canvas_writer
module tb_canvas_writer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i;
  logic [31:0] cmd_data_i;
  logic        cmd_ready_o;
  logic        busy_o;
  logic        we_o;
  logic [8:0]  col_o;
  logic [7:0]  row_o;
  logic [7:0]  data_o;

  int errors = 0;
  int checks = 0;

  canvas_writer dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_data_i  (cmd_data_i),
    .cmd_ready_o (cmd_ready_o),
    .busy_o      (busy_o),
    .we_o        (we_o),
    .col_o       (col_o),
    .row_o       (row_o),
    .data_o      (data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cmd(input int op, input int a, input int b);
    return (32'(op) << 28) | (32'(b) << 9) | 32'(a);
  endfunction

  // Drive inputs for the coming rising edge, then return at the following falling edge
  task automatic cyc(input logic v, input logic [31:0] d);
    cmd_valid_i = v;
    cmd_data_i  = d;
    @(negedge clk_i);
  endtask

  initial begin
    int n;
    int guard;
    int post;
    rst_i       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_data_i  = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_we", we_o, 0);
    chk("rst_ready", cmd_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_col", col_o, 0);
    chk("rst_row", row_o, 0);
    chk("rst_data", data_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Colour, position, two plots back to back
    cyc(1'b1, cmd(1, 'hA5, 0));
    chk("t1_we0", we_o, 0);
    chk("t1_rdy0", cmd_ready_o, 1);
    cyc(1'b1, cmd(2, 10, 3));
    chk("t1_we1", we_o, 0);
    chk("t1_rdy1", cmd_ready_o, 1);
    cyc(1'b1, cmd(3, 0, 0));
    chk("t1_p0_we", we_o, 1);
    chk("t1_p0_col", col_o, 10);
    chk("t1_p0_row", row_o, 3);
    chk("t1_p0_data", data_o, 'hA5);
    chk("t1_p0_rdy", cmd_ready_o, 1);
    cyc(1'b1, cmd(3, 0, 0));
    chk("t1_p1_we", we_o, 1);
    chk("t1_p1_col", col_o, 11);
    chk("t1_p1_row", row_o, 3);
    chk("t1_p1_data", data_o, 'hA5);
    chk("t1_p1_rdy", cmd_ready_o, 1);
    cyc(1'b0, '0);
    chk("t1_idle_we", we_o, 0);
    chk("t1_idle_col", col_o, 11);
    chk("t1_idle_rdy", cmd_ready_o, 1);

    // Plot at the last pixel wraps to the origin
    cyc(1'b1, cmd(2, 319, 239));
    cyc(1'b1, cmd(3, 0, 0));
    chk("t2_a_we", we_o, 1);
    chk("t2_a_col", col_o, 319);
    chk("t2_a_row", row_o, 239);
    cyc(1'b1, cmd(3, 0, 0));
    chk("t2_b_we", we_o, 1);
    chk("t2_b_col", col_o, 0);
    chk("t2_b_row", row_o, 0);
    cyc(1'b0, '0);

    // 3x2 fill with a SET_COLOR held pending during the fill
    cyc(1'b1, cmd(2, 5, 5));
    cyc(1'b1, cmd(4, 3, 2));
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t3_we%0d", i), we_o, 1);
      chk($sformatf("t3_col%0d", i), col_o, 5 + (i % 3));
      chk($sformatf("t3_row%0d", i), row_o, 5 + (i / 3));
      chk($sformatf("t3_data%0d", i), data_o, 'hA5);
      chk($sformatf("t3_rdy%0d", i), cmd_ready_o, (i == 5) ? 1 : 0);
      chk($sformatf("t3_busy%0d", i), busy_o, (i == 5) ? 0 : 1);
      cyc(1'b1, cmd(1, 'h3C, 0));
    end
    chk("t3_after_we", we_o, 0);
    chk("t3_after_rdy", cmd_ready_o, 1);
    cyc(1'b1, cmd(3, 0, 0));
    chk("t3_plot_col", col_o, 5);
    chk("t3_plot_row", row_o, 5);
    chk("t3_plot_data", data_o, 'h3C);
    cyc(1'b0, '0);

    // Fill crossing the right edge is clipped but keeps its cycles
    cyc(1'b1, cmd(2, 318, 0));
    cyc(1'b1, cmd(4, 4, 1));
    cmd_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_we%0d", i), we_o, (i < 2) ? 1 : 0);
      chk($sformatf("t4_col%0d", i), col_o, (i < 2) ? 318 + i : 319);
      chk($sformatf("t4_rdy%0d", i), cmd_ready_o, (i == 3) ? 1 : 0);
      cyc(1'b0, '0);
    end
    chk("t4_after_we", we_o, 0);

    // Zero-size fill and unknown opcode are single-cycle no-ops
    cyc(1'b1, cmd(4, 0, 7));
    chk("t5_fill0_we", we_o, 0);
    chk("t5_fill0_rdy", cmd_ready_o, 1);
    chk("t5_fill0_busy", busy_o, 0);
    cyc(1'b1, cmd(15, 0, 0));
    chk("t5_opf_we", we_o, 0);
    chk("t5_opf_rdy", cmd_ready_o, 1);
    cyc(1'b0, '0);
    chk("t5_end_we", we_o, 0);

    // Full clear in raster order, aborted by reset after 1000 writes
    cyc(1'b1, cmd(1, 0, 0));
    cyc(1'b1, cmd(5, 0, 0));
    cmd_valid_i = 1'b0;
    n = 0;
    guard = 0;
    while (n < 1000 && guard < 2000) begin
      if (we_o) begin
        if (col_o != 9'(n % 320) || row_o != 8'(n / 320) || data_o != 8'h00) begin
          chk($sformatf("t6_px%0d_col", n), col_o, n % 320);
          chk($sformatf("t6_px%0d_row", n), row_o, n / 320);
          chk($sformatf("t6_px%0d_data", n), data_o, 0);
        end
        n++;
      end
      if (n < 1000) @(negedge clk_i);
      guard++;
    end
    chk("t6_write_count", n, 1000);
    chk("t6_busy_mid", busy_o, 1);
    chk("t6_rdy_mid", cmd_ready_o, 0);
    chk("t6_last_col", col_o, 999 % 320);
    chk("t6_last_row", row_o, 999 / 320);
    rst_i = 1'b1;
    #1;
    chk("t6_rst_we", we_o, 0);
    chk("t6_rst_rdy", cmd_ready_o, 1);
    chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_col", col_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    post = 0;
    repeat (20) begin
      @(negedge clk_i);
      if (we_o) post++;
    end
    chk("t6_post_writes", post, 0);
    chk("t6_post_rdy", cmd_ready_o, 1);
    chk("t6_post_busy", busy_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
